mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch stage and the memory-access stage of the 5-stage pipeline. Accepts one request per requester, issues at most one outstanding memory transaction, routes the response back to its owner, and exposes per-requester stall signals to the pipeline. Default priority goes to data; a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while fetch waits (≥1)

- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `if_req_i` in 1, fetch read request
- `if_addr_i` in ADDR_W, fetch address
- `if_gnt_o` out 1, fetch request accepted this cycle
- `if_rvalid_o` out 1, fetch read data valid (one-cycle pulse)
- `if_rdata_o` out DATA_W, fetch read data
- `if_stall_o` out 1, `if_req_i & ~if_gnt_o`
- `dm_req_i` in 1, data request
- `dm_we_i` in 1, 1 = write
- `dm_be_i` in DATA_W/8, byte enables (writes)
- `dm_addr_i` in ADDR_W, data address
- `dm_wdata_i` in DATA_W, write data
- `dm_gnt_o` out 1, data request accepted
- `dm_rvalid_o` out 1, response pulse (read data, or write ack)
- `dm_rdata_o` out DATA_W, data read data
- `dm_stall_o` out 1, `dm_req_i & ~dm_gnt_o`
- `mem_req_o` out 1, transaction issue (one-cycle pulse)
- `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` out, transaction fields, valid with `mem_req_o`
- `mem_rvalid_i` in 1, memory response (read data or write ack), any latency ≥1
- `mem_rdata_i` in DATA_W, memory read data

## Operation
- FSM: IDLE, WAIT. Owner register: NONE, IF, DM.
- IDLE: if any request, pick winner, assert its `*_gnt_o` and `mem_req_o` combinationally the same cycle, drive winner's fields onto `mem_*`, latch owner, go WAIT. No request: stay IDLE, all outputs 0.
- WAIT: no grants, `mem_req_o`=0. On `mem_rvalid_i`: pulse owner's `*_rvalid_o`, pass `mem_rdata_i` to owner's `*_rdata_o` (non-owner rdata holds 0), owner←NONE, go IDLE.
- Arbitration when both request: DM wins unless `streak == MAX_DATA_STREAK`, then IF wins.
- `streak` (width $clog2(MAX_DATA_STREAK+1)): +1 on a DM grant while `if_req_i`=1; cleared on any IF grant, and on a DM grant with `if_req_i`=0. Saturates at MAX.
- Requesters hold req and fields stable until granted; dropping req before grant is legal (withdraw, no effect).
- `mem_rvalid_i` in IDLE is ignored (no rvalid forwarded, no state change).

## Timing
- Reset: state IDLE, owner NONE, streak 0; all outputs 0.
- Grant latency: 0 cycles from request in IDLE. Response to requester: same cycle as `mem_rvalid_i` (combinational from input).
- Max throughput: one transaction per 2 cycles (issue cycle + response cycle in WAIT); next grant earliest the cycle after the response.
- `rst` during WAIT: returns to IDLE next cycle; in-flight response is dropped (arrives in IDLE, ignored).
- `rst` asserted same cycle as requests: no grant issued.

## Structure
- Shared package `risky_pkg`: `mem_owner_e` {OWN_NONE, OWN_IF, OWN_DM}, `mem_arb_state_e` {ARB_IDLE, ARB_WAIT}.
- No sub-module; FSM, owner register and streak counter inline (~150–200 lines).

## Test plan
- Fetch only: `if_req_i`=1, addr 0x100; memory responds after 3 cycles with 0xDEADBEEF -> `if_gnt_o`, `mem_req_o` same cycle, `mem_addr_o`=0x100, `if_rvalid_o` pulse with 0xDEADBEEF, `dm_rvalid_o`=0.
- Simultaneous: both request -> DM granted, `if_stall_o`=1 until DM response; IF granted in next IDLE cycle.
- Starvation: DM requests continuously with IF pending, MAX=4 -> grants DM,DM,DM,DM,IF,DM…; streak reads 0 after IF grant.
- Write: `dm_we_i`=1, be 0x3, addr 0x40, wdata 0x1234 -> `mem_we_o`=1, `mem_be_o`=0x3, `dm_rvalid_o` pulse on ack.
- Reset mid-WAIT: assert `rst` one cycle during WAIT, then deliver `mem_rvalid_i` -> no rvalid pulse, state IDLE, outputs 0.
- Withdraw / stray response: `if_req_i` dropped while DM owns port -> no IF grant later; `mem_rvalid_i` in IDLE -> no output change.

Source files
------------

// File: rtl/risky_pkg.sv
// risky_pkg: shared pipeline types for the memory-port arbiter
// Contents:
//   mem_owner_e     - which requester currently owns the outstanding transaction
//   mem_arb_state_e - arbiter FSM states
package risky_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } mem_owner_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } mem_arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of fetch, data and memory-side signals around the arbiter
// Signals:
//   if_*  - instruction-fetch requester (req/addr in, gnt/rvalid/rdata/stall out)
//   dm_*  - memory-access requester (req/we/be/addr/wdata in, gnt/rvalid/rdata/stall out)
//   mem_* - unified memory port (req/we/be/addr/wdata out, rvalid/rdata in)
// Modports:
//   slave  - arbiter view
//   master - environment view (pipeline stages plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_W-1:0]     if_rdata_o;
    logic                  if_stall_o;
    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [DATA_W/8-1:0]   dm_be_i;
    logic [ADDR_W-1:0]     dm_addr_i;
    logic [DATA_W-1:0]     dm_wdata_i;
    logic                  dm_gnt_o;
    logic                  dm_rvalid_o;
    logic [DATA_W-1:0]     dm_rdata_o;
    logic                  dm_stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_rvalid_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_stall_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_stall_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages, one transaction in flight
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - mem_port_arbiter_if.slave: fetch/data requesters and the memory port
// Parameters:
//   MAX_DATA_STREAK - data grants allowed in a row while fetch waits (>=1)
module mem_port_arbiter
    import risky_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    mem_arb_state_e       r_state;
    mem_arb_state_e       w_state_nxt;
    mem_owner_e           r_owner;
    logic [STREAK_W-1:0]  r_streak;
    logic                 w_pick_if;
    logic                 w_issue;
    logic                 w_if_gnt;
    logic                 w_dm_gnt;
    logic                 w_rsp;

    // Data wins by default; fetch wins when it is alone or data has used up its streak.
    assign w_pick_if = bus.if_req_i & (~bus.dm_req_i | (r_streak == STREAK_MAX));
    // Reset suppresses grants and responses in the same cycle.
    assign w_issue   = ~rst & (r_state == ARB_IDLE);
    assign w_if_gnt  = w_issue & bus.if_req_i & w_pick_if;
    assign w_dm_gnt  = w_issue & bus.dm_req_i & ~w_pick_if;
    assign w_rsp     = ~rst & (r_state == ARB_WAIT) & bus.mem_rvalid_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ARB_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ARB_IDLE) w_state_nxt = (w_if_gnt | w_dm_gnt) ? ARB_WAIT : ARB_IDLE;
        else                     w_state_nxt = w_rsp ? ARB_IDLE : ARB_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= OWN_NONE;
            r_streak <= '0;
        end else begin
            if (w_if_gnt)      r_owner <= OWN_IF;
            else if (w_dm_gnt) r_owner <= OWN_DM;
            else if (w_rsp)    r_owner <= OWN_NONE;
            // Streak only grows while fetch is actually being held off, and saturates.
            if (w_if_gnt)
                r_streak <= '0;
            else if (w_dm_gnt)
                r_streak <= ~bus.if_req_i ? '0 :
                            (r_streak == STREAK_MAX) ? r_streak : r_streak + STREAK_W'(1);
        end
    end

    always_comb begin
        bus.if_gnt_o    = w_if_gnt;
        bus.dm_gnt_o    = w_dm_gnt;
        bus.if_stall_o  = bus.if_req_i & ~w_if_gnt;
        bus.dm_stall_o  = bus.dm_req_i & ~w_dm_gnt;
        bus.mem_req_o   = w_if_gnt | w_dm_gnt;
        bus.mem_we_o    = w_dm_gnt & bus.dm_we_i;
        bus.mem_be_o    = w_dm_gnt ? bus.dm_be_i : '0;
        bus.mem_addr_o  = w_if_gnt ? bus.if_addr_i : w_dm_gnt ? bus.dm_addr_i : '0;
        bus.mem_wdata_o = w_dm_gnt ? bus.dm_wdata_i : '0;
        bus.if_rvalid_o = w_rsp & (r_owner == OWN_IF);
        bus.dm_rvalid_o = w_rsp & (r_owner == OWN_DM);
        bus.if_rdata_o  = (w_rsp & (r_owner == OWN_IF)) ? bus.mem_rdata_i : '0;
        bus.dm_rdata_o  = (w_rsp & (r_owner == OWN_DM)) ? bus.mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (MAX_DATA_STREAK=4)
module tb_mem_port_arbiter;
    import risky_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_be_i      = '0;
        bus.dm_addr_i    = '0;
        bus.dm_wdata_i   = '0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        // reset held while requests are present: nothing granted
        bus.if_req_i = 1'b1;
        bus.dm_req_i = 1'b1;
        #1;
        chk("rst_if_gnt", 32'(bus.if_gnt_o), 0);
        chk("rst_dm_gnt", 32'(bus.dm_gnt_o), 0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 0);
        tick();
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_state", 32'(dut.r_state), 32'(ARB_IDLE));
        chk("reset_streak", 32'(dut.r_streak), 0);
        chk("reset_mem_addr", bus.mem_addr_o, 0);
        chk("reset_if_rdata", bus.if_rdata_o, 0);

        // fetch only, response 3 cycles after issue
        tick();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        #1;
        chk("fo_if_gnt", 32'(bus.if_gnt_o), 1);
        chk("fo_mem_req", 32'(bus.mem_req_o), 1);
        chk("fo_mem_addr", bus.mem_addr_o, 32'h100);
        chk("fo_mem_we", 32'(bus.mem_we_o), 0);
        chk("fo_if_stall", 32'(bus.if_stall_o), 0);
        tick();
        bus.if_req_i = 1'b0;
        #1;
        chk("fo_wait_mem_req", 32'(bus.mem_req_o), 0);
        tick();
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("fo_if_rvalid", 32'(bus.if_rvalid_o), 1);
        chk("fo_if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
        chk("fo_dm_rvalid", 32'(bus.dm_rvalid_o), 0);
        chk("fo_dm_rdata", bus.dm_rdata_o, 0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        #1;
        chk("fo_if_rvalid_end", 32'(bus.if_rvalid_o), 0);

        // simultaneous requests: data first, fetch stalls until the next idle cycle
        tick();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h104;
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h200;
        #1;
        chk("sim_dm_gnt", 32'(bus.dm_gnt_o), 1);
        chk("sim_if_gnt", 32'(bus.if_gnt_o), 0);
        chk("sim_if_stall", 32'(bus.if_stall_o), 1);
        chk("sim_mem_addr", bus.mem_addr_o, 32'h200);
        tick();
        bus.dm_req_i = 1'b0;
        #1;
        chk("sim_wait_if_stall", 32'(bus.if_stall_o), 1);
        chk("sim_wait_if_gnt", 32'(bus.if_gnt_o), 0);
        chk("sim_streak1", 32'(dut.r_streak), 1);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h55;
        #1;
        chk("sim_dm_rvalid", 32'(bus.dm_rvalid_o), 1);
        chk("sim_dm_rdata", bus.dm_rdata_o, 32'h55);
        chk("sim_if_rvalid", 32'(bus.if_rvalid_o), 0);
        chk("sim_rsp_if_stall", 32'(bus.if_stall_o), 1);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("sim_if_gnt_next", 32'(bus.if_gnt_o), 1);
        chk("sim_if_mem_addr", bus.mem_addr_o, 32'h104);
        tick();
        bus.if_req_i = 1'b0;
        #1;
        chk("sim_streak_clr", 32'(dut.r_streak), 0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h66;
        #1;
        chk("sim_if_rvalid2", 32'(bus.if_rvalid_o), 1);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // starvation: both held, grants go DM x4, IF, DM
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h108;
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h300;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("starve_if_gnt%0d", k), 32'(bus.if_gnt_o), 32'(k == 4));
            chk($sformatf("starve_dm_gnt%0d", k), 32'(bus.dm_gnt_o), 32'(k != 4));
            tick();
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'(k);
            #1;
            chk($sformatf("starve_rsp%0d", k), 32'(k == 4 ? bus.if_rvalid_o : bus.dm_rvalid_o), 1);
            if (k == 4) chk("starve_streak_clr", 32'(dut.r_streak), 0);
            tick();
            bus.mem_rvalid_i = 1'b0;
        end
        clear_inputs();

        // data write
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_be_i    = 4'h3;
        bus.dm_addr_i  = 32'h40;
        bus.dm_wdata_i = 32'h1234;
        #1;
        chk("wr_dm_gnt", 32'(bus.dm_gnt_o), 1);
        chk("wr_mem_we", 32'(bus.mem_we_o), 1);
        chk("wr_mem_be", 32'(bus.mem_be_o), 32'h3);
        chk("wr_mem_addr", bus.mem_addr_o, 32'h40);
        chk("wr_mem_wdata", bus.mem_wdata_o, 32'h1234);
        tick();
        clear_inputs();
        tick();
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("wr_dm_ack", 32'(bus.dm_rvalid_o), 1);
        tick();
        clear_inputs();

        // reset while waiting drops the in-flight response
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h110;
        #1;
        chk("rw_if_gnt", 32'(bus.if_gnt_o), 1);
        tick();
        bus.if_req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFE;
        #1;
        chk("rw_if_rvalid", 32'(bus.if_rvalid_o), 0);
        chk("rw_if_rdata", bus.if_rdata_o, 0);
        chk("rw_state", 32'(dut.r_state), 32'(ARB_IDLE));
        chk("rw_mem_req", 32'(bus.mem_req_o), 0);
        tick();
        clear_inputs();

        // withdraw: fetch drops its request while data owns the port
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h500;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h120;
        #1;
        chk("wd_dm_gnt", 32'(bus.dm_gnt_o), 1);
        tick();
        bus.dm_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("wd_dm_rvalid", 32'(bus.dm_rvalid_o), 1);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("wd_if_gnt", 32'(bus.if_gnt_o), 0);
        chk("wd_mem_req", 32'(bus.mem_req_o), 0);

        // stray response in idle
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hAAAA;
        #1;
        chk("stray_if_rvalid", 32'(bus.if_rvalid_o), 0);
        chk("stray_dm_rvalid", 32'(bus.dm_rvalid_o), 0);
        chk("stray_dm_rdata", bus.dm_rdata_o, 0);
        chk("stray_mem_req", 32'(bus.mem_req_o), 0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("stray_state", 32'(dut.r_state), 32'(ARB_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
